// File: rtl/alu8_reg.sv
// rtl/alu8_reg.sv - registered 16-op ALU with carry/borrow in and out
module alu8_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  input  logic             F,
  output logic [WIDTH-1:0] R,
  output logic             D
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_ADC   = 4'd5;
  localparam logic [3:0] OP_SBB   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_ROL   = 4'd10;
  localparam logic [3:0] OP_ROR   = 4'd11;
  localparam logic [3:0] OP_INC   = 4'd12;
  localparam logic [3:0] OP_DEC   = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;
  localparam logic [3:0] OP_CLR   = 4'd15;

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   f_ext;
  logic [WIDTH:0]   one_ext;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res_next;
  logic             d_next;

  assign a_ext   = {1'b0, A};
  assign b_ext   = {1'b0, B};
  assign f_ext   = {{WIDTH{1'b0}}, F};
  assign one_ext = {{WIDTH{1'b0}}, 1'b1};

  // Add/subtract results are formed one bit wider; for subtracts the extra bit
  // is the two's-complement sign, which equals the borrow.
  always_comb begin
    wide     = '0;
    res_next = '0;
    d_next   = 1'b0;
    unique case (op)
      OP_ADD:   wide = a_ext + b_ext;
      OP_SUB:   wide = a_ext - b_ext;
      OP_ADC:   wide = a_ext + b_ext + f_ext;
      OP_SBB:   wide = a_ext - b_ext - f_ext;
      OP_INC:   wide = a_ext + one_ext;
      OP_DEC:   wide = a_ext - one_ext;
      default:  wide = '0;
    endcase
    unique case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_INC, OP_DEC: begin
        res_next = wide[WIDTH-1:0];
        d_next   = wide[WIDTH];
      end
      OP_AND:   res_next = A & B;
      OP_OR:    res_next = A | B;
      OP_XOR:   res_next = A ^ B;
      OP_NOT:   res_next = ~A;
      OP_SHL: begin
        res_next = {A[WIDTH-2:0], 1'b0};
        d_next   = A[WIDTH-1];
      end
      OP_SHR: begin
        res_next = {1'b0, A[WIDTH-1:1]};
        d_next   = A[0];
      end
      OP_ROL: begin
        res_next = {A[WIDTH-2:0], A[WIDTH-1]};
        d_next   = A[WIDTH-1];
      end
      OP_ROR: begin
        res_next = {A[0], A[WIDTH-1:1]};
        d_next   = A[0];
      end
      OP_PASSB: res_next = B;
      OP_CLR:   res_next = '0;
      default:  res_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R <= '0;
      D <= 1'b0;
    end else begin
      R <= res_next;
      D <= d_next;
    end
  end

endmodule

// File: tb/tb_alu8_reg.sv
// tb/tb_alu8_reg.sv - scoreboard bench for alu8_reg against an arithmetic model
module tb_alu8_reg;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] op;
  logic       F;
  logic [7:0] R;
  logic       D;

  int checks;
  int errors;

  typedef struct {
    int r;
    int d;
    int op;
    int a;
    int b;
    int f;
  } exp_t;

  exp_t exp_q[$];

  alu8_reg #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .op(op),
    .F(F),
    .R(R),
    .D(D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b, input int o, input int f);
    exp_t e;
    int t;
    e.op = o; e.a = a; e.b = b; e.f = f;
    e.r = 0; e.d = 0;
    case (o)
      0:  begin t = a + b;         e.r = t % 256; e.d = (t > 255); end
      1:  begin e.r = (a - b + 256) % 256;     e.d = (a < b); end
      2:  e.r = a & b;
      3:  e.r = a | b;
      4:  e.r = a ^ b;
      5:  begin t = a + b + f;     e.r = t % 256; e.d = (t > 255); end
      6:  begin e.r = (a - b - f + 512) % 256; e.d = (a < b + f); end
      7:  e.r = 255 - a;
      8:  begin e.r = (a * 2) % 256;           e.d = (a >= 128); end
      9:  begin e.r = a / 2;                   e.d = a % 2; end
      10: begin e.r = (a * 2) % 256 + a / 128; e.d = (a >= 128); end
      11: begin e.r = a / 2 + (a % 2) * 128;   e.d = a % 2; end
      12: begin e.r = (a + 1) % 256;           e.d = (a == 255); end
      13: begin e.r = (a + 255) % 256;         e.d = (a == 0); end
      14: e.r = b;
      default: e.r = 0;
    endcase
    return e;
  endfunction

  task automatic issue(input int a, input int b, input int o, input int f);
    @(negedge clk);
    A  = a[7:0];
    B  = b[7:0];
    op = o[3:0];
    F  = f[0];
    exp_q.push_back(model(a, b, o, f));
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (R !== 8'h00 || D !== 1'b0) begin
      errors++;
      $display("FAIL %s: got R=%h D=%b, want R=00 D=0", name, R, D);
    end
  endtask

  // Monitor: every edge out of reset retires the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (R !== e.r[7:0] || D !== e.d[0]) begin
          errors++;
          $display("FAIL op%0d A=%0d B=%0d F=%0d: got R=%h D=%b, want R=%h D=%0d",
                   e.op, e.a, e.b, e.f, R, D, e.r[7:0], e.d);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    A = 8'd3; B = 8'd1; op = 4'd0; F = 1'b0;

    #2 rst = 1'b1;
    #1 check_reset_state("async_reset_assert");
    @(posedge clk); #1;
    check_reset_state("reset_held_over_edge");
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(model(3, 1, 0, 0));

    // Arithmetic corners
    issue(128, 128, 0, 0);
    issue(2, 1, 1, 0);
    issue(4, 5, 1, 0);
    issue(255, 0, 12, 0);
    issue(0, 0, 13, 0);
    // Carry-in ops and F ignored elsewhere
    issue(4, 5, 5, 1);
    issue(4, 5, 6, 1);
    issue(4, 5, 0, 1);
    issue(255, 255, 5, 1);
    issue(0, 255, 6, 1);
    issue(7, 3, 2, 1);
    // Logic ops
    issue(255, 0, 2, 0);
    issue(5, 6, 3, 0);
    issue(128, 128, 4, 0);
    issue(4, 0, 7, 0);
    issue(0, 5, 14, 0);
    issue(200, 100, 15, 1);
    // Shifts and rotates
    issue(8'h81, 0, 8, 0);
    issue(8'h81, 0, 9, 0);
    issue(8'h81, 0, 10, 0);
    issue(8'h81, 0, 11, 0);

    // Back-to-back random traffic
    for (int i = 0; i < 200; i++)
      issue($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 15), $urandom_range(0, 1));

    // Reset between edges discards the in-flight operation
    for (int i = 0; i < 10; i++)
      issue($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 15), $urandom_range(0, 1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1 check_reset_state("async_reset_midstream");
    @(posedge clk); #1;
    check_reset_state("midstream_reset_held");
    @(negedge clk);
    A = 8'd200; B = 8'd100; op = 4'd1; F = 1'b0;
    rst = 1'b0;
    exp_q.push_back(model(200, 100, 1, 0));
    for (int i = 0; i < 20; i++)
      issue($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 15), $urandom_range(0, 1));

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding results, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
